// File: rtl/relu_maxpool_stage.sv
// rtl/relu_maxpool_stage.sv - optional ReLU followed by 2x2 stride-2 max-pooling
// over a raster stream, using a half-row line buffer of pooled row-pair maxima.
module relu_maxpool_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_SIZE   = 5,
  parameter int SIGNED_IN  = 0,
  localparam int OUT_SIZE  = IMG_SIZE / 2,
  localparam int CW        = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1,
  localparam int IW        = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  frame_start,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [CW-1:0]         out_row,
  output logic [CW-1:0]         out_col,
  output logic                  frame_done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_next;
  logic [IW-1:0]         in_row, in_col;
  logic [IW-1:0]         row_eff, col_eff;
  logic [DATA_WIDTH-1:0] pair_reg;
  logic [DATA_WIDTH-1:0] v, pm, line_rd, win_max;
  logic [CW-1:0]         lb_idx;
  logic                  col_wrap, row_wrap, last, in_win;
  logic [DATA_WIDTH-1:0] linebuf [OUT_SIZE];

  // A pixel arriving with frame_start, or while idle, is always (0,0).
  always_comb begin
    row_eff  = (frame_start || state == IDLE) ? '0 : in_row;
    col_eff  = (frame_start || state == IDLE) ? '0 : in_col;
    v        = (SIGNED_IN != 0 && in_data[DATA_WIDTH-1]) ? '0 : in_data;
    pm       = (v > pair_reg) ? v : pair_reg;
    lb_idx   = CW'(col_eff >> 1);
    line_rd  = linebuf[lb_idx];
    win_max  = (line_rd > pm) ? line_rd : pm;
    col_wrap = (32'(col_eff) == IMG_SIZE - 1);
    row_wrap = (32'(row_eff) == IMG_SIZE - 1);
    last     = col_wrap && row_wrap;
    in_win   = (32'(row_eff) < 2 * OUT_SIZE) && (32'(col_eff) < 2 * OUT_SIZE);
  end

  always_comb begin
    state_next = state;
    if (in_valid) begin
      state_next = last ? IDLE : RUN;
    end else if (frame_start) begin
      state_next = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_row     <= '0;
      in_col     <= '0;
      pair_reg   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start) begin
        in_row   <= '0;
        in_col   <= '0;
        pair_reg <= '0;
      end
      if (in_valid) begin
        in_col     <= col_wrap ? '0 : col_eff + 1'b1;
        in_row     <= col_wrap ? (row_wrap ? '0 : row_eff + 1'b1) : row_eff;
        frame_done <= last;
        if (in_win) begin
          if (!col_eff[0]) begin
            pair_reg <= v;
          end else if (row_eff[0]) begin
            out_data  <= win_max;
            out_row   <= CW'(row_eff >> 1);
            out_col   <= CW'(col_eff >> 1);
            out_valid <= 1'b1;
          end
        end
      end
    end
  end

  // Even rows deposit the horizontal pair maximum; odd rows read it back.
  always_ff @(posedge clk) begin
    if (in_valid && in_win && col_eff[0] && !row_eff[0]) begin
      linebuf[lb_idx] <= pm;
    end
  end

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// tb/tb_relu_maxpool_stage.sv - directed bench for relu_maxpool_stage with three
// configurations (5x5 unsigned, 5x5 signed, 4x4 unsigned) sharing one input stream.
module tb_relu_maxpool_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        frame_start;

  logic [15:0] d0, d1, d2;
  logic        v0, v1, v2;
  logic [0:0]  r0, r1, r2, c0, c1, c2;
  logic        f0, f1, f2;

  int          sel;
  logic [15:0] o_data;
  logic        o_valid, o_done;
  logic [0:0]  o_row, o_col;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  relu_maxpool_stage #(.DATA_WIDTH(16), .IMG_SIZE(5), .SIGNED_IN(0)) u_u5 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .frame_start(frame_start),
    .out_data(d0), .out_valid(v0), .out_row(r0), .out_col(c0), .frame_done(f0));

  relu_maxpool_stage #(.DATA_WIDTH(16), .IMG_SIZE(5), .SIGNED_IN(1)) u_s5 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .frame_start(frame_start),
    .out_data(d1), .out_valid(v1), .out_row(r1), .out_col(c1), .frame_done(f1));

  relu_maxpool_stage #(.DATA_WIDTH(16), .IMG_SIZE(4), .SIGNED_IN(0)) u_u4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .frame_start(frame_start),
    .out_data(d2), .out_valid(v2), .out_row(r2), .out_col(c2), .frame_done(f2));

  always_comb begin
    o_data  = d0; o_valid = v0; o_row = r0; o_col = c0; o_done = f0;
    if (sel == 1) begin
      o_data = d1; o_valid = v1; o_row = r1; o_col = c1; o_done = f1;
    end else if (sel == 2) begin
      o_data = d2; o_valid = v2; o_row = r2; o_col = c2; o_done = f2;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " out_valid"}, 32'(o_valid), 0);
    check({tag, " frame_done"}, 32'(o_done), 0);
  endtask

  // Present one pixel at a negedge; outputs are checked on the following negedge.
  task automatic send_pix(input logic [15:0] pix, input bit fs, input bit ev,
                          input int ed, input int er, input int ec, input bit edone,
                          input int gap_max);
    int gap;
    in_data = pix; in_valid = 1'b1; frame_start = fs;
    @(negedge clk);
    in_valid = 1'b0; frame_start = 1'b0;
    check("out_valid", 32'(o_valid), 32'(ev));
    if (ev) begin
      check("out_data", 32'(o_data), ed);
      check("out_row", 32'(o_row), er);
      check("out_col", 32'(o_col), ec);
    end
    check("frame_done", 32'(o_done), 32'(edone));
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check_idle("gap");
    end
  endtask

  // kind 0: ramp row*img+col; kind 1: 0xFF00 everywhere except (1,1)=3.
  task automatic run_frame(input int s, input int kind, input int gap_max, input bit fs_first);
    int img, os, ed;
    logic [15:0] pix;
    bit ev;
    sel = s;
    img = (s == 2) ? 4 : 5;
    os  = img / 2;
    for (int r = 0; r < img; r++) begin
      for (int c = 0; c < img; c++) begin
        pix = (kind == 0) ? 16'(r * img + c) : ((r == 1 && c == 1) ? 16'h0003 : 16'hFF00);
        ev  = (r < 2 * os) && (c < 2 * os) && (r % 2 == 1) && (c % 2 == 1);
        ed  = (kind == 0) ? (r * img + c) : ((r == 1 && c == 1) ? 3 : 0);
        send_pix(pix, fs_first && r == 0 && c == 0, ev, ed, r / 2, c / 2,
                 (r == img - 1) && (c == img - 1), gap_max);
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    sel = 0; rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst out_data", 32'(d0), 0);
    check("rst out_valid", 32'(v0), 0);
    check("rst out_row", 32'(r0), 0);
    check("rst out_col", 32'(c0), 0);
    check("rst frame_done", 32'(f0), 0);
    check("rst out_data s5", 32'(d1), 0);
    check("rst out_data u4", 32'(d2), 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, 0, 0, 1'b0);
    run_frame(0, 0, 3, 1'b0);
    run_frame(1, 1, 0, 1'b0);

    // Abort: seven ramp pixels (pixel 6 legitimately closes window (0,0)),
    // then frame_start together with pixel (0,0) of a fresh frame.
    sel = 0;
    for (int i = 0; i < 7; i++) begin
      send_pix(16'(i), 1'b0, i == 6, 6, 0, 0, 1'b0, 0);
    end
    run_frame(0, 0, 0, 1'b1);

    // Asynchronous reset in the middle of row 1.
    for (int i = 0; i < 8; i++) begin
      send_pix(16'(i), 1'b0, i == 6, 6, 0, 0, 1'b0, 0);
    end
    #2 rst = 1'b1;
    #1;
    check("async out_data", 32'(d0), 0);
    check("async out_valid", 32'(v0), 0);
    check("async out_row", 32'(r0), 0);
    check("async out_col", 32'(c0), 0);
    check("async frame_done", 32'(f0), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post reset");
    run_frame(0, 0, 0, 1'b0);

    // 4x4 back-to-back frames.
    pulse_reset();
    run_frame(2, 0, 0, 1'b0);
    run_frame(2, 0, 0, 1'b0);
    @(negedge clk);
    check_idle("tail");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
